// File: rtl/convnet_layer_seq_pkg.sv
// Shared types and helpers for the conv layer sequencer.
package convnet_layer_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNSHUF = 3'd1,
    ST_LOAD   = 3'd2,
    ST_COMP   = 3'd3,
    ST_ADV    = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_IDLE      = 2'd0,
    MODE_UNSHUF    = 2'd1,
    MODE_CONV      = 2'd2,
    MODE_CONV_POOL = 2'd3
  } mode_e;

  // Weight words consumed by one output-channel group; an input group count
  // of zero is treated as a single group.
  function automatic int unsigned weight_words(input int unsigned ch_num,
                                               input int unsigned ich);
    return ch_num * ch_num * ((ich == 0) ? 1 : ich);
  endfunction

endpackage

// File: rtl/convnet_addr_gen.sv
// Weight/bias base address generator. Bases persist across groups and
// layers so parameters are packed contiguously in layer order.
module convnet_addr_gen
  import convnet_layer_seq_pkg::*;
#(
  parameter int CH_NUM   = 4,
  parameter int WADDR_BW = 10,
  parameter int BADDR_BW = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic                i_adv,
  input  logic [WADDR_BW-1:0] i_w_inc,
  output logic [WADDR_BW-1:0] o_w_base,
  output logic [BADDR_BW-1:0] o_b_base
);

  localparam logic [BADDR_BW-1:0] B_INC = BADDR_BW'(CH_NUM);

  logic [WADDR_BW-1:0] r_w_base;
  logic [BADDR_BW-1:0] r_b_base;

  // Base registers: cleared on reset/clear, stepped by one group on advance
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_w_base <= '0;
      r_b_base <= '0;
    end else if (i_adv) begin
      r_w_base <= r_w_base + i_w_inc;
      r_b_base <= r_b_base + B_INC;
    end
  end

  assign o_w_base = r_w_base;
  assign o_b_base = r_b_base;

endmodule

// File: rtl/convnet_layer_seq.sv
// Layer sequencer for the conv datapath: unshuffle, then NUM_LAYERS conv
// layers, each a load/compute pass per output-channel group, ping-ponging
// activations between SRAM groups A and B.
module convnet_layer_seq
  import convnet_layer_seq_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int CH_NUM     = 4,
  parameter int GRP_BW     = 4,
  parameter int WADDR_BW   = 10,
  parameter int BADDR_BW   = 6,
  localparam int LIDX_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         abort,
  input  logic [NUM_LAYERS*GRP_BW-1:0] cfg_och_grp,
  input  logic [NUM_LAYERS*GRP_BW-1:0] cfg_ich_grp,
  input  logic [NUM_LAYERS-1:0]        cfg_pool,
  output logic                         busy,
  output logic                         valid,
  output logic                         unshuf_start,
  output logic                         load_start,
  output logic                         comp_start,
  input  logic                         unshuf_done,
  input  logic                         load_done,
  input  logic                         comp_done,
  output logic [1:0]                   mode,
  output logic                         src_bank,
  output logic [LIDX_W-1:0]            layer_idx,
  output logic [GRP_BW-1:0]            och_idx,
  output logic [WADDR_BW-1:0]          w_base,
  output logic [BADDR_BW-1:0]          b_base
);

  state_e              r_state, w_state_nxt;
  logic [GRP_BW-1:0]   r_och_grp [NUM_LAYERS];
  logic [GRP_BW-1:0]   r_ich_grp [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] r_pool;
  logic [LIDX_W-1:0]   r_layer, w_layer_nxt;
  logic [GRP_BW-1:0]   r_och, w_och_nxt;
  logic                r_bank, w_bank_nxt;
  logic                r_unshuf_start, r_load_start, r_comp_start;
  logic                w_latch, w_addr_clr, w_addr_adv;
  logic                w_first_found, w_next_found;
  logic [LIDX_W-1:0]   w_first_idx, w_next_idx;
  logic [GRP_BW:0]     w_och_inc;
  logic                w_och_more;
  logic [WADDR_BW-1:0] w_w_inc;

  // Config snapshot taken when a run is accepted; ignored mid-run
  always_ff @(posedge clk) begin
    if (w_latch) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_och_grp[i] <= cfg_och_grp[i*GRP_BW +: GRP_BW];
        r_ich_grp[i] <= cfg_ich_grp[i*GRP_BW +: GRP_BW];
      end
      r_pool <= cfg_pool;
    end
  end

  // Locate the first non-empty layer overall and the next one after r_layer
  always_comb begin
    w_first_found = 1'b0;
    w_first_idx   = '0;
    w_next_found  = 1'b0;
    w_next_idx    = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (r_och_grp[i] != '0) begin
        w_first_found = 1'b1;
        w_first_idx   = LIDX_W'(i);
        if (i > int'(r_layer)) begin
          w_next_found = 1'b1;
          w_next_idx   = LIDX_W'(i);
        end
      end
    end
  end

  assign w_och_inc  = {1'b0, r_och} + (GRP_BW+1)'(1);
  assign w_och_more = w_och_inc < {1'b0, r_och_grp[r_layer]};
  assign w_w_inc    = WADDR_BW'(weight_words(CH_NUM, int'(r_ich_grp[r_layer])));

  // Next-state and counter updates; abort overrides any done pulse
  always_comb begin
    w_state_nxt = r_state;
    w_layer_nxt = r_layer;
    w_och_nxt   = r_och;
    w_bank_nxt  = r_bank;
    w_latch     = 1'b0;
    w_addr_clr  = 1'b0;
    w_addr_adv  = 1'b0;
    if (r_state != ST_IDLE && abort) begin
      w_state_nxt = ST_IDLE;
      w_layer_nxt = '0;
      w_och_nxt   = '0;
      w_bank_nxt  = 1'b0;
      w_addr_clr  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            w_state_nxt = ST_UNSHUF;
            w_latch     = 1'b1;
            w_addr_clr  = 1'b1;
            w_layer_nxt = '0;
            w_och_nxt   = '0;
            w_bank_nxt  = 1'b0;
          end
        end
        ST_UNSHUF: begin
          // done in the start cycle is a stale pulse, not a completion
          if (unshuf_done && !r_unshuf_start) begin
            w_och_nxt  = '0;
            w_bank_nxt = 1'b0;
            w_addr_clr = 1'b1;
            if (w_first_found) begin
              w_layer_nxt = w_first_idx;
              w_state_nxt = ST_LOAD;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          if (load_done && !r_load_start) w_state_nxt = ST_COMP;
        end
        ST_COMP: begin
          if (comp_done && !r_comp_start) w_state_nxt = ST_ADV;
        end
        ST_ADV: begin
          w_addr_adv = 1'b1;
          if (w_och_more) begin
            w_och_nxt   = w_och_inc[GRP_BW-1:0];
            w_state_nxt = ST_LOAD;
          end else begin
            w_och_nxt  = '0;
            w_bank_nxt = ~r_bank;
            if (w_next_found) begin
              w_layer_nxt = w_next_idx;
              w_state_nxt = ST_LOAD;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
          w_layer_nxt = '0;
          w_och_nxt   = '0;
          w_bank_nxt  = 1'b0;
          w_addr_clr  = 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, counters and one-cycle start pulses on entry to each engine state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_layer        <= '0;
      r_och          <= '0;
      r_bank         <= 1'b0;
      r_unshuf_start <= 1'b0;
      r_load_start   <= 1'b0;
      r_comp_start   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_layer        <= w_layer_nxt;
      r_och          <= w_och_nxt;
      r_bank         <= w_bank_nxt;
      r_unshuf_start <= (w_state_nxt == ST_UNSHUF) && (r_state != ST_UNSHUF);
      r_load_start   <= (w_state_nxt == ST_LOAD)   && (r_state != ST_LOAD);
      r_comp_start   <= (w_state_nxt == ST_COMP)   && (r_state != ST_COMP);
    end
  end

  // Mode decode from the current state and latched pool flag
  always_comb begin
    mode = MODE_IDLE;
    case (r_state)
      ST_UNSHUF:              mode = MODE_UNSHUF;
      ST_LOAD, ST_COMP, ST_ADV: mode = r_pool[r_layer] ? MODE_CONV_POOL : MODE_CONV;
      default:                mode = MODE_IDLE;
    endcase
  end

  convnet_addr_gen #(
    .CH_NUM   (CH_NUM),
    .WADDR_BW (WADDR_BW),
    .BADDR_BW (BADDR_BW)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_addr_clr),
    .i_adv    (w_addr_adv),
    .i_w_inc  (w_w_inc),
    .o_w_base (w_base),
    .o_b_base (b_base)
  );

  assign busy         = (r_state != ST_IDLE);
  assign valid        = (r_state == ST_DONE);
  assign unshuf_start = r_unshuf_start;
  assign load_start   = r_load_start;
  assign comp_start   = r_comp_start;
  assign src_bank     = r_bank;
  assign layer_idx    = r_layer;
  assign och_idx      = r_och;

endmodule

// File: tb/tb_convnet_layer_seq.sv
// Directed bench for convnet_layer_seq with 3-cycle engine responders.
module tb_convnet_layer_seq;

  logic        clk = 1'b0;
  logic        rst_n, enable, abort;
  logic [11:0] cfg_och_grp, cfg_ich_grp;
  logic [2:0]  cfg_pool;
  logic        busy, valid, unshuf_start, load_start, comp_start;
  logic        unshuf_done, load_done, comp_done;
  logic [1:0]  mode;
  logic        src_bank;
  logic [1:0]  layer_idx;
  logic [3:0]  och_idx;
  logic [9:0]  w_base;
  logic [5:0]  b_base;

  convnet_layer_seq dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort),
    .cfg_och_grp(cfg_och_grp), .cfg_ich_grp(cfg_ich_grp), .cfg_pool(cfg_pool),
    .busy(busy), .valid(valid),
    .unshuf_start(unshuf_start), .load_start(load_start), .comp_start(comp_start),
    .unshuf_done(unshuf_done), .load_done(load_done), .comp_done(comp_done),
    .mode(mode), .src_bank(src_bank), .layer_idx(layer_idx), .och_idx(och_idx),
    .w_base(w_base), .b_base(b_base)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int cnt_u, cnt_l, cnt_c, cnt_v, valid_cyc, gap;
  logic busy_after;
  bit killed, timeout;
  logic [31:0] snap;
  int rec_w [8];
  int rec_b [8];
  int rec_bank [8];
  int rec_mode [8];
  int rec_layer [8];

  // Runs one sequence with engines answering 3 cycles after each start.
  // abort_layer: assert abort with comp_done in that layer (-1: never).
  // rst_load_n: pulse rst_n low on the n-th load_start (0: never).
  task automatic run_auto(input int abort_layer, input int rst_load_n,
                          input bit stray, input bit cfg_flip);
    int ucd, lcd, ccd, last_comp_c;
    bit fin, kill_pending, valid_prev;
    ucd = 0; lcd = 0; ccd = 0; last_comp_c = 0;
    fin = 0; kill_pending = 0; valid_prev = 0;
    cnt_u = 0; cnt_l = 0; cnt_c = 0; cnt_v = 0; valid_cyc = -1; gap = -1;
    busy_after = 1'b1; killed = 0; timeout = 0; snap = '1;
    for (int i = 0; i < 8; i++) begin
      rec_w[i] = -1; rec_b[i] = -1; rec_bank[i] = -1; rec_mode[i] = -1; rec_layer[i] = -1;
    end
    enable = 1'b1;
    for (int c = 1; c <= 300 && !fin; c++) begin
      @(posedge clk); #1;
      enable = 1'b0; unshuf_done = 1'b0; load_done = 1'b0; comp_done = 1'b0;
      if (kill_pending) begin
        snap = {2'b00, busy, valid, mode, src_bank, layer_idx, och_idx, w_base, b_base,
                unshuf_start, load_start, comp_start};
        abort = 1'b0; rst_n = 1'b1; killed = 1; fin = 1;
      end else begin
        if (valid_prev) begin busy_after = busy; fin = 1; end
        if (valid) begin cnt_v++; valid_cyc = c; valid_prev = 1; end
        if (cfg_flip && c == 2) begin
          cfg_och_grp = {4'd3, 4'd3, 4'd3}; cfg_ich_grp = {4'd3, 4'd3, 4'd3}; cfg_pool = 3'b111;
        end
        if (unshuf_start) begin cnt_u++; ucd = 3; end
        else if (ucd > 0) begin ucd--; if (ucd == 0) unshuf_done = 1'b1; end
        if (load_start) begin
          cnt_l++; lcd = 3;
          if (cnt_c > 0) gap = c - last_comp_c;
          if (rst_load_n == cnt_l) begin rst_n = 1'b0; kill_pending = 1; end
        end else if (lcd > 0) begin lcd--; if (lcd == 0) load_done = 1'b1; end
        if (comp_start) begin
          if (cnt_c < 8) begin
            rec_w[cnt_c] = int'(w_base); rec_b[cnt_c] = int'(b_base);
            rec_bank[cnt_c] = int'(src_bank); rec_mode[cnt_c] = int'(mode);
            rec_layer[cnt_c] = int'(layer_idx);
          end
          cnt_c++; last_comp_c = c; ccd = 3;
          if (stray) comp_done = 1'b1;
        end else if (ccd > 0) begin
          ccd--;
          if (stray && ccd == 2) load_done = 1'b1;
          if (ccd == 0) begin
            comp_done = 1'b1;
            if (int'(layer_idx) == abort_layer) begin abort = 1'b1; kill_pending = 1; end
          end
        end
      end
    end
    if (!fin) timeout = 1;
    enable = 1'b0; unshuf_done = 1'b0; load_done = 1'b0; comp_done = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    snap = {2'b00, busy, valid, mode, src_bank, layer_idx, och_idx, w_base, b_base,
            unshuf_start, load_start, comp_start};
    n_tests++;
    if (snap !== 32'd0) begin n_fail++; $display("FAIL reset_outputs: got %h exp 0", snap); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_defaults();
    int eb [3] = '{0, 1, 0};
    int ew [3] = '{0, 16, 32};
    int eb2 [3] = '{0, 4, 8};
    cfg_och_grp = {4'd1, 4'd1, 4'd1}; cfg_ich_grp = {4'd1, 4'd1, 4'd1}; cfg_pool = 3'b000;
    run_auto(-1, 0, 0, 0);
    n_tests++; if (timeout) begin n_fail++; $display("FAIL t1_timeout: got 1 exp 0"); end
    n_tests++; if (cnt_u !== 1) begin n_fail++; $display("FAIL t1_unshuf_starts: got %0d exp 1", cnt_u); end
    n_tests++; if (cnt_l !== 3) begin n_fail++; $display("FAIL t1_load_starts: got %0d exp 3", cnt_l); end
    n_tests++; if (cnt_c !== 3) begin n_fail++; $display("FAIL t1_comp_starts: got %0d exp 3", cnt_c); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (rec_bank[i] !== eb[i] || rec_w[i] !== ew[i] || rec_b[i] !== eb2[i]) begin
        n_fail++;
        $display("FAIL t1_pass%0d: bank/w/b got %0d/%0d/%0d exp %0d/%0d/%0d",
                 i, rec_bank[i], rec_w[i], rec_b[i], eb[i], ew[i], eb2[i]);
      end
      n_tests++;
      if (rec_mode[i] !== 2) begin n_fail++; $display("FAIL t1_mode%0d: got %0d exp 2", i, rec_mode[i]); end
    end
    n_tests++; if (cnt_v !== 1) begin n_fail++; $display("FAIL t1_valid_count: got %0d exp 1", cnt_v); end
    n_tests++; if (valid_cyc !== 32) begin n_fail++; $display("FAIL t1_valid_cycle: got %0d exp 32", valid_cyc); end
    n_tests++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL t1_busy_after_valid: got %b exp 0", busy_after); end
    n_tests++; if (gap !== 5) begin n_fail++; $display("FAIL t1_comp_to_load_gap: got %0d exp 5", gap); end
  endtask

  task automatic test_groups_pool();
    int ew [6] = '{0, 16, 32, 64, 80, 96};
    int eb2 [6] = '{0, 4, 8, 12, 16, 20};
    int em [6] = '{2, 2, 2, 3, 3, 3};
    int ebk [6] = '{0, 0, 1, 0, 0, 0};
    int el [6] = '{0, 0, 1, 2, 2, 2};
    cfg_och_grp = {4'd3, 4'd1, 4'd2}; cfg_ich_grp = {4'd1, 4'd2, 4'd1}; cfg_pool = 3'b100;
    run_auto(-1, 0, 0, 0);
    n_tests++; if (cnt_c !== 6) begin n_fail++; $display("FAIL t2_comp_passes: got %0d exp 6", cnt_c); end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (rec_w[i] !== ew[i] || rec_b[i] !== eb2[i] || rec_mode[i] !== em[i] ||
          rec_bank[i] !== ebk[i] || rec_layer[i] !== el[i]) begin
        n_fail++;
        $display("FAIL t2_pass%0d: w/b/mode/bank/layer got %0d/%0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d/%0d",
                 i, rec_w[i], rec_b[i], rec_mode[i], rec_bank[i], rec_layer[i],
                 ew[i], eb2[i], em[i], ebk[i], el[i]);
      end
    end
    n_tests++; if (cnt_v !== 1) begin n_fail++; $display("FAIL t2_valid_count: got %0d exp 1", cnt_v); end
  endtask

  task automatic test_zero_group();
    cfg_och_grp = {4'd1, 4'd0, 4'd1}; cfg_ich_grp = {4'd1, 4'd1, 4'd1}; cfg_pool = 3'b000;
    run_auto(-1, 0, 0, 0);
    n_tests++; if (cnt_c !== 2) begin n_fail++; $display("FAIL t3_comp_passes: got %0d exp 2", cnt_c); end
    n_tests++;
    if (rec_bank[0] !== 0 || rec_bank[1] !== 1) begin
      n_fail++; $display("FAIL t3_banks: got %0d,%0d exp 0,1", rec_bank[0], rec_bank[1]);
    end
    n_tests++;
    if (rec_layer[0] !== 0 || rec_layer[1] !== 2) begin
      n_fail++; $display("FAIL t3_layers: got %0d,%0d exp 0,2", rec_layer[0], rec_layer[1]);
    end
    n_tests++;
    if (rec_w[1] !== 16 || rec_b[1] !== 4) begin
      n_fail++; $display("FAIL t3_bases: got w=%0d b=%0d exp w=16 b=4", rec_w[1], rec_b[1]);
    end
    n_tests++; if (cnt_v !== 1) begin n_fail++; $display("FAIL t3_valid_count: got %0d exp 1", cnt_v); end
  endtask

  task automatic test_abort();
    cfg_och_grp = {4'd1, 4'd1, 4'd1}; cfg_ich_grp = {4'd1, 4'd1, 4'd1}; cfg_pool = 3'b000;
    run_auto(1, 0, 0, 0);
    n_tests++; if (!killed) begin n_fail++; $display("FAIL t4_abort_reached: got 0 exp 1"); end
    n_tests++; if (snap !== 32'd0) begin n_fail++; $display("FAIL t4_after_abort: got %h exp 0", snap); end
    n_tests++; if (cnt_v !== 0) begin n_fail++; $display("FAIL t4_no_valid: got %0d exp 0", cnt_v); end
    run_auto(-1, 0, 0, 0);
    n_tests++;
    if (cnt_c !== 3 || rec_layer[0] !== 0 || rec_w[0] !== 0 || cnt_v !== 1) begin
      n_fail++;
      $display("FAIL t4_restart: passes/layer0/w0/valid got %0d/%0d/%0d/%0d exp 3/0/0/1",
               cnt_c, rec_layer[0], rec_w[0], cnt_v);
    end
  endtask

  task automatic test_stray_done();
    cfg_och_grp = {4'd1, 4'd1, 4'd1}; cfg_ich_grp = {4'd1, 4'd1, 4'd1}; cfg_pool = 3'b000;
    load_done = 1'b1; comp_done = 1'b1; unshuf_done = 1'b1;
    @(posedge clk); #1;
    load_done = 1'b0; comp_done = 1'b0; unshuf_done = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || unshuf_start !== 1'b0) begin
      n_fail++; $display("FAIL t5_idle_stray: busy=%b unshuf_start=%b exp 0 0", busy, unshuf_start);
    end
    run_auto(-1, 0, 1, 0);
    n_tests++; if (gap !== 5) begin n_fail++; $display("FAIL t5_comp_to_load_gap: got %0d exp 5", gap); end
    n_tests++; if (valid_cyc !== 32) begin n_fail++; $display("FAIL t5_valid_cycle: got %0d exp 32", valid_cyc); end
    n_tests++;
    if (cnt_c !== 3 || cnt_v !== 1) begin
      n_fail++; $display("FAIL t5_completion: passes/valid got %0d/%0d exp 3/1", cnt_c, cnt_v);
    end
  endtask

  task automatic test_cfg_latch();
    cfg_och_grp = {4'd1, 4'd1, 4'd1}; cfg_ich_grp = {4'd1, 4'd1, 4'd1}; cfg_pool = 3'b000;
    run_auto(-1, 0, 0, 1);
    n_tests++; if (cnt_c !== 3) begin n_fail++; $display("FAIL t6_latched_passes: got %0d exp 3", cnt_c); end
    n_tests++;
    if (rec_mode[2] !== 2 || rec_w[2] !== 32) begin
      n_fail++; $display("FAIL t6_latched_cfg: mode/w got %0d/%0d exp 2/32", rec_mode[2], rec_w[2]);
    end
    cfg_och_grp = {4'd1, 4'd1, 4'd1}; cfg_ich_grp = {4'd1, 4'd1, 4'd1}; cfg_pool = 3'b000;
  endtask

  task automatic test_reset_mid_load();
    cfg_och_grp = {4'd1, 4'd1, 4'd1}; cfg_ich_grp = {4'd1, 4'd1, 4'd1}; cfg_pool = 3'b000;
    run_auto(-1, 2, 0, 0);
    n_tests++; if (!killed) begin n_fail++; $display("FAIL t6_reset_reached: got 0 exp 1"); end
    n_tests++; if (snap !== 32'd0) begin n_fail++; $display("FAIL t6_after_reset: got %h exp 0", snap); end
    run_auto(-1, 0, 0, 0);
    n_tests++;
    if (cnt_c !== 3 || cnt_v !== 1) begin
      n_fail++; $display("FAIL t6_run_after_reset: passes/valid got %0d/%0d exp 3/1", cnt_c, cnt_v);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; abort = 1'b0;
    unshuf_done = 1'b0; load_done = 1'b0; comp_done = 1'b0;
    cfg_och_grp = '0; cfg_ich_grp = '0; cfg_pool = '0;
    test_reset();
    test_defaults();
    test_groups_pool();
    test_zero_group();
    test_abort();
    test_stray_done();
    test_cfg_latch();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
